// File: rtl/game_mode_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : game_mode_sequencer_if
// Purpose  : Request, engine-handshake and display signals of the game sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface game_mode_sequencer_if;
  logic       go;
  logic [1:0] mode;
  logic [2:0] game_done;
  logic [4:0] game_value;
  logic [1:0] mux_sel;
  logic [2:0] game_start;
  logic [4:0] result;
  logic       result_valid;
  logic       busy;
  logic       error;

  modport master (
    output go, mode, game_done, game_value,
    input  mux_sel, game_start, result, result_valid, busy, error
  );

  modport slave (
    input  go, mode, game_done, game_value,
    output mux_sel, game_start, result, result_valid, busy, error
  );
endinterface
`default_nettype wire

// File: rtl/game_mode_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : game_mode_sequencer
// Purpose  : Selects a game engine, starts it, captures its result for display.
//            Optional WAIT watchdog enabled by macro SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module game_mode_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  wire logic            clk,
  input  wire logic            reset,
  game_mode_sequencer_if.slave bus
);

  localparam int unsigned      C_HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("game_mode_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("game_mode_sequencer: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mux_sel_q, mux_sel_d;
  logic [2:0]          game_start_q, game_start_d;
  logic [4:0]          result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic [C_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                w_done_sel;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned       C_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT_CYCLES - 1);
  logic [C_WD_W-1:0]            wd_cnt_q, wd_cnt_d;
`endif

  // Only the engine currently routed through the mux may complete the wait.
  assign w_done_sel = bus.game_done[mux_sel_q];

  always_comb begin
    state_d      = state_q;
    mux_sel_d    = mux_sel_q;
    game_start_d = 3'b000;
    result_d     = result_q;
    error_d      = 1'b0;
    hold_cnt_d   = '0;
`ifdef SEQ_TIMEOUT_EN
    wd_cnt_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          if (bus.mode == 2'b11) begin
            error_d = 1'b1;
          end else begin
            mux_sel_d    = bus.mode;
            game_start_d = 3'b001 << bus.mode;
            state_d      = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done_sel) begin
          result_d = bus.game_value;
          state_d  = ST_SHOW;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_cnt_q == C_WD_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + C_WD_W'(1);
        end
`endif
      end
      ST_SHOW: begin
        if (hold_cnt_q == C_HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + C_HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are registered from the next state so they align with it.
    result_valid_d = (state_d == ST_SHOW);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      mux_sel_q      <= 2'b00;
      game_start_q   <= 3'b000;
      result_q       <= 5'b00000;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      mux_sel_q      <= mux_sel_d;
      game_start_q   <= game_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign bus.mux_sel      = mux_sel_q;
  assign bus.game_start   = game_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_game_mode_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_game_mode_sequencer
// Purpose  : Self-checking bench; result captures tracked through a scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_game_mode_sequencer;

  localparam int unsigned HOLD_CYCLES    = 4;
  localparam int unsigned TIMEOUT_CYCLES = 8;

  logic clk;
  logic reset;
  game_mode_sequencer_if bus ();

  game_mode_sequencer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_total = 0;
  int        n_bad   = 0;
  logic [4:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_mux"},   32'(bus.mux_sel), 32'd0);
    check_val({tag, "_start"}, 32'(bus.game_start), 32'd0);
    check_val({tag, "_res"},   32'(bus.result), 32'd0);
    check_val({tag, "_vld"},   32'(bus.result_valid), 32'd0);
    check_val({tag, "_busy"},  32'(bus.busy), 32'd0);
    check_val({tag, "_err"},   32'(bus.error), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    check_val({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // Scoreboard side: every result_valid rising edge consumes one expectation.
  logic prev_valid = 1'b0;
  int   valid_len  = 0;
  always @(negedge clk) begin
    if (bus.result_valid && !prev_valid) begin
      check_val("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_val("sb_result", 32'(bus.result), 32'(exp_q.pop_front()));
    end
    if (bus.result_valid) begin
      valid_len++;
      if (!bus.busy) check_val("busy_in_show", 32'(bus.busy), 32'd1);
    end else if (prev_valid) begin
      check_val("hold_len", 32'(valid_len), 32'(HOLD_CYCLES));
      check_val("busy_fall", 32'(bus.busy), 32'd0);
      valid_len = 0;
    end
    prev_valid = bus.result_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.go         = 1'b0;
    bus.mode       = 2'b00;
    bus.game_done  = 3'b000;
    bus.game_value = 5'b00000;
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Even/odd roulette, full round trip
    bus.go = 1'b1; bus.mode = 2'b01;
    tick();
    bus.go = 1'b0;
    check_val("t1_mux",   32'(bus.mux_sel), 32'd1);
    check_val("t1_start", 32'(bus.game_start), 32'b010);
    check_val("t1_busy",  32'(bus.busy), 32'd1);
    tick();
    check_val("t1_start_off", 32'(bus.game_start), 32'd0);
    bus.game_done = 3'b010; bus.game_value = 5'b10110; exp_q.push_back(5'b10110);
    tick();
    bus.game_done = 3'b000;
    check_val("t1_res", 32'(bus.result), 32'b10110);
    check_val("t1_vld", 32'(bus.result_valid), 32'd1);
    wait_idle("t1", 20);
    check_val("t1_res_keep", 32'(bus.result), 32'b10110);

    // Regular roulette, non-selected done bits ignored
    bus.go = 1'b1; bus.mode = 2'b00;
    tick();
    bus.go = 1'b0;
    check_val("t2_start", 32'(bus.game_start), 32'b001);
    tick();
    bus.game_done = 3'b110; bus.game_value = 5'b11111;
    tick();
    bus.game_done = 3'b000;
    check_val("t2_ign_vld",  32'(bus.result_valid), 32'd0);
    check_val("t2_ign_busy", 32'(bus.busy), 32'd1);
    check_val("t2_ign_res",  32'(bus.result), 32'b10110);
    bus.game_done = 3'b001; bus.game_value = 5'b00111; exp_q.push_back(5'b00111);
    tick();
    bus.game_done = 3'b000;
    check_val("t2_res", 32'(bus.result), 32'b00111);
    wait_idle("t2", 20);

    // Select blackjack so the illegal request has a non-reset mux_sel to preserve
    bus.go = 1'b1; bus.mode = 2'b10;
    tick();
    bus.go = 1'b0;
    check_val("t3_start", 32'(bus.game_start), 32'b100);
    tick();
    bus.go = 1'b1; bus.mode = 2'b01;
    tick();
    bus.go = 1'b0;
    check_val("t3_wait_start", 32'(bus.game_start), 32'd0);
    check_val("t3_wait_mux",   32'(bus.mux_sel), 32'd2);
    bus.game_done = 3'b100; bus.game_value = 5'b01010; exp_q.push_back(5'b01010);
    tick();
    bus.game_done = 3'b000;
    bus.go = 1'b1; bus.mode = 2'b00;
    tick();
    bus.go = 1'b0;
    check_val("t3_show_start", 32'(bus.game_start), 32'd0);
    check_val("t3_show_mux",   32'(bus.mux_sel), 32'd2);
    wait_idle("t3", 20);
    check_val("t3_no_restart", 32'(bus.game_start), 32'd0);

    // Illegal mode
    bus.go = 1'b1; bus.mode = 2'b11;
    tick();
    bus.go = 1'b0;
    check_val("t4_err",   32'(bus.error), 32'd1);
    check_val("t4_busy",  32'(bus.busy), 32'd0);
    check_val("t4_mux",   32'(bus.mux_sel), 32'd2);
    check_val("t4_start", 32'(bus.game_start), 32'd0);
    tick();
    check_val("t4_err_off", 32'(bus.error), 32'd0);

    // Reset while waiting on blackjack
    bus.go = 1'b1; bus.mode = 2'b10;
    tick();
    bus.go = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("t5");
    bus.game_done = 3'b100; bus.game_value = 5'b11100;
    tick();
    bus.game_done = 3'b000;
    check_reset_vals("t5_post");

    // go coincident with reset is dropped
    reset = 1'b1; bus.go = 1'b1; bus.mode = 2'b01;
    tick();
    reset = 1'b0; bus.go = 1'b0;
    tick();
    check_val("t6_busy", 32'(bus.busy), 32'd0);
    check_val("t6_mux",  32'(bus.mux_sel), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    bus.go = 1'b1; bus.mode = 2'b00;
    tick();
    bus.go = 1'b0;
    tick();
    bus.game_done = 3'b001; bus.game_value = 5'b00101; exp_q.push_back(5'b00101);
    tick();
    bus.game_done = 3'b000;
    wait_idle("t7a", 20);

    // Watchdog expiry after TIMEOUT_CYCLES cycles in WAIT
    bus.go = 1'b1; bus.mode = 2'b00;
    tick();
    bus.go = 1'b0;
    tick();
    for (int i = 0; i < int'(TIMEOUT_CYCLES) - 1; i++) tick();
    check_val("t7_pre_busy", 32'(bus.busy), 32'd1);
    check_val("t7_pre_err",  32'(bus.error), 32'd0);
    tick();
    check_val("t7_err",  32'(bus.error), 32'd1);
    check_val("t7_busy", 32'(bus.busy), 32'd0);
    check_val("t7_vld",  32'(bus.result_valid), 32'd0);
    check_val("t7_res",  32'(bus.result), 32'b00101);
    tick();
    check_val("t7_err_off", 32'(bus.error), 32'd0);

    // Done on the expiry cycle wins
    bus.go = 1'b1; bus.mode = 2'b00;
    tick();
    bus.go = 1'b0;
    tick();
    for (int i = 0; i < int'(TIMEOUT_CYCLES) - 1; i++) tick();
    bus.game_done = 3'b001; bus.game_value = 5'b01001; exp_q.push_back(5'b01001);
    tick();
    bus.game_done = 3'b000;
    check_val("t8_err", 32'(bus.error), 32'd0);
    check_val("t8_vld", 32'(bus.result_valid), 32'd1);
    check_val("t8_res", 32'(bus.result), 32'b01001);
    wait_idle("t8", 20);
`endif

    tick();
    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
